// File: rtl/vga_frame_scanner_pkg.sv
// Shared timing defaults and the raster decode record for the VGA frame scanner.
package vga_frame_scanner_pkg;

    // Wide enough for the 1056-tick line and 628-line frame of SVGA 800x600.
    localparam int unsigned CNT_W = 11;

    localparam int unsigned IMG_W_DFLT    = 540;
    localparam int unsigned IMG_H_DFLT    = 540;
    localparam int unsigned ADDR_W_DFLT   = 19;
    localparam int unsigned CLK_DIV_DFLT  = 1;
    localparam int unsigned H_ACTIVE_DFLT = 800;
    localparam int unsigned H_FP_DFLT     = 40;
    localparam int unsigned H_SYNC_DFLT   = 128;
    localparam int unsigned H_BP_DFLT     = 88;
    localparam int unsigned V_ACTIVE_DFLT = 600;
    localparam int unsigned V_FP_DFLT     = 1;
    localparam int unsigned V_SYNC_DFLT   = 4;
    localparam int unsigned V_BP_DFLT     = 23;
    localparam int unsigned X_OFF_DFLT    = 130;
    localparam int unsigned Y_OFF_DFLT    = 30;

    typedef struct packed {
        logic active;
        logic win;
        logic hs;
        logic vs;
    } raster_t;

endpackage

// File: rtl/vga_frame_scanner_timing_gen.sv
// Pixel-tick divider, horizontal/vertical raster counters and per-position raster decode.
module vga_frame_scanner_timing_gen
    import vga_frame_scanner_pkg::*;
#(
    parameter int unsigned IMG_W    = IMG_W_DFLT,
    parameter int unsigned IMG_H    = IMG_H_DFLT,
    parameter int unsigned CLK_DIV  = CLK_DIV_DFLT,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DFLT,
    parameter int unsigned H_FP     = H_FP_DFLT,
    parameter int unsigned H_SYNC   = H_SYNC_DFLT,
    parameter int unsigned H_BP     = H_BP_DFLT,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DFLT,
    parameter int unsigned V_FP     = V_FP_DFLT,
    parameter int unsigned V_SYNC   = V_SYNC_DFLT,
    parameter int unsigned V_BP     = V_BP_DFLT,
    parameter int unsigned X_OFF    = X_OFF_DFLT,
    parameter int unsigned Y_OFF    = Y_OFF_DFLT
) (
    input  logic    clk,
    input  logic    rst,
    output logic    tick_o,
    output logic    frame_start_o,
    output raster_t raster_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic [CNT_W-1:0] h_rel, v_rel;
    logic             active;

    assign tick_o        = (div_q == '0);
    assign frame_start_o = (h_q == '0) && (v_q == '0);

    always_comb begin
        div_d = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + DIV_W'(1);
        h_d   = h_q;
        v_d   = v_q;
        if (tick_o) begin
            if (h_q == CNT_W'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_q + CNT_W'(1);
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    // Offsets wrap below zero, so one unsigned compare bounds both window edges.
    assign h_rel = h_q - CNT_W'(X_OFF);
    assign v_rel = v_q - CNT_W'(Y_OFF);

    always_comb begin
        active        = (h_q < CNT_W'(H_ACTIVE)) && (v_q < CNT_W'(V_ACTIVE));
        raster_o.active = active;
        raster_o.win  = active && (h_rel < CNT_W'(IMG_W)) && (v_rel < CNT_W'(IMG_H));
        raster_o.hs   = (h_q >= CNT_W'(H_ACTIVE + H_FP)) &&
                        (h_q <  CNT_W'(H_ACTIVE + H_FP + H_SYNC));
        raster_o.vs   = (v_q >= CNT_W'(V_ACTIVE + V_FP)) &&
                        (v_q <  CNT_W'(V_ACTIVE + V_FP + V_SYNC));
    end

endmodule

// File: rtl/vga_frame_scanner.sv
// Writes the incoming pixel stream into a frame BRAM and scans it out with VGA raster timing.
module vga_frame_scanner
    import vga_frame_scanner_pkg::*;
#(
    parameter int unsigned IMG_W    = IMG_W_DFLT,
    parameter int unsigned IMG_H    = IMG_H_DFLT,
    parameter int unsigned ADDR_W   = ADDR_W_DFLT,
    parameter int unsigned CLK_DIV  = CLK_DIV_DFLT,
    parameter int unsigned H_ACTIVE = H_ACTIVE_DFLT,
    parameter int unsigned H_FP     = H_FP_DFLT,
    parameter int unsigned H_SYNC   = H_SYNC_DFLT,
    parameter int unsigned H_BP     = H_BP_DFLT,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DFLT,
    parameter int unsigned V_FP     = V_FP_DFLT,
    parameter int unsigned V_SYNC   = V_SYNC_DFLT,
    parameter int unsigned V_BP     = V_BP_DFLT,
    parameter int unsigned X_OFF    = X_OFF_DFLT,
    parameter int unsigned Y_OFF    = Y_OFF_DFLT,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        pixel_i,
    input  logic              pixel_en_i,
    output logic              fb_we_o,
    output logic [ADDR_W-1:0] fb_waddr_o,
    output logic [7:0]        fb_wdata_o,
    output logic [ADDR_W-1:0] fb_raddr_o,
    input  logic [7:0]        fb_rdata_i,
    output logic [9:0]        wr_row_o,
    output logic              frame_done_o,
    output logic [7:0]        vga_pix_o,
    output logic              de_o,
    output logic              hsync_o,
    output logic              vsync_o
);

    logic [ADDR_W-1:0] wptr_q, wptr_d, waddr_q;
    logic [CNT_W-1:0]  col_q, col_d, row_q, row_d;
    logic [9:0]        wr_row_q, wr_row_d;
    logic [7:0]        wdata_q;
    logic              we_q, done_q, last_col, last_px;

    always_comb begin
        last_col = (col_q == CNT_W'(IMG_W - 1));
        last_px  = last_col && (row_q == CNT_W'(IMG_H - 1));
        wptr_d   = wptr_q;
        col_d    = col_q;
        row_d    = row_q;
        wr_row_d = wr_row_q;
        if (pixel_en_i) begin
            if (last_px) begin
                wptr_d   = '0;
                col_d    = '0;
                row_d    = '0;
                wr_row_d = '0;
            end else begin
                wptr_d = wptr_q + ADDR_W'(1);
                if (last_col) begin
                    col_d    = '0;
                    row_d    = row_q + CNT_W'(1);
                    wr_row_d = wr_row_q + 10'd1;
                end else begin
                    col_d = col_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            wr_row_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            col_q    <= col_d;
            row_q    <= row_d;
            wr_row_q <= wr_row_d;
            we_q     <= pixel_en_i;
            done_q   <= pixel_en_i && last_px;
            if (pixel_en_i) begin
                waddr_q <= wptr_q;
                wdata_q <= pixel_i;
            end
        end
    end

    assign fb_we_o      = we_q;
    assign fb_waddr_o   = waddr_q;
    assign fb_wdata_o   = wdata_q;
    assign wr_row_o     = wr_row_q;
    assign frame_done_o = done_q;

    logic              tick, frame_start;
    raster_t           raster, s1_q;
    logic [ADDR_W-1:0] rptr_q, rhold_q;
    logic [7:0]        pix_q;
    logic              de_q, hs_q, vs_q;

    vga_frame_scanner_timing_gen #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .X_OFF    (X_OFF),
        .Y_OFF    (Y_OFF)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .tick_o        (tick),
        .frame_start_o (frame_start),
        .raster_o      (raster)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q  <= '0;
            rhold_q <= '0;
            s1_q    <= '0;
            pix_q   <= '0;
            de_q    <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
        end else if (tick) begin
            rhold_q <= rptr_q;
            if (frame_start) begin
                rptr_q <= '0;
            end else if (raster.win) begin
                rptr_q <= rptr_q + ADDR_W'(1);
            end
            s1_q  <= raster;
            pix_q <= s1_q.win ? fb_rdata_i : 8'h00;
            de_q  <= s1_q.active;
            hs_q  <= s1_q.hs ? HS_POL : ~HS_POL;
            vs_q  <= s1_q.vs ? VS_POL : ~VS_POL;
        end
    end

    // rptr advances on the tick, so hold the issued address until the next tick samples the data.
    assign fb_raddr_o = tick ? rptr_q : rhold_q;
    assign vga_pix_o  = pix_q;
    assign de_o       = de_q;
    assign hsync_o    = hs_q;
    assign vsync_o    = vs_q;

endmodule
